// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: coin encoding, coin values and FSM states.
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        CoinNickel  = 2'd0,
        CoinDime    = 2'd1,
        CoinQuarter = 2'd2,
        CoinDollar  = 2'd3
    } coin_t;

    localparam int unsigned COIN_VALUE [4] = '{5, 10, 25, 100};

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StIssue,
        StFinish
    } state_t;

    function automatic logic [6:0] coin_value(coin_t c);
        return 7'(COIN_VALUE[c]);
    endfunction

endpackage

// File: rtl/change_dispenser_coin_bin.sv
// Per-denomination hopper inventory: saturating refill, single-coin dispense, empty flag.
module change_dispenser_coin_bin
    import change_dispenser_pkg::*;
#(
    parameter int unsigned INV_W = 8,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [INV_W-1:0] inc_count,
    input  logic             dec,
    output logic [INV_W-1:0] count,
    output logic             empty
);

    logic [INV_W:0]   sum;
    logic [INV_W-1:0] sat;

    // Refill saturates first; a same-cycle dispense then removes one coin.
    always_comb begin
        sum = {1'b0, count} + (inc ? {1'b0, inc_count} : '0);
        sat = sum[INV_W] ? '1 : sum[INV_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= INV_W'(INIT);
        end else if (dec && sat != '0) begin
            count <= sat - INV_W'(1);
        end else begin
            count <= sat;
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy largest-first change dispenser driving a coin-eject handshake to the hopper.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMOUNT_W     = 9,
    parameter int unsigned INV_W        = 8,
    parameter int unsigned NICKEL_INIT  = 40,
    parameter int unsigned DIME_INIT    = 40,
    parameter int unsigned QUARTER_INIT = 40,
    parameter int unsigned DOLLAR_INIT  = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    output logic                coin_valid,
    output logic [1:0]          coin_type,
    input  logic                coin_ready,
    input  logic                refill_valid,
    input  logic [1:0]          refill_type,
    input  logic [INV_W-1:0]    refill_count,
    output logic                busy,
    output logic                done,
    output logic [AMOUNT_W-1:0] shortfall,
    output logic [3:0]          bin_empty
);

    state_t              state;
    logic [AMOUNT_W-1:0] remaining;
    coin_t               coin_sel;

    logic [INV_W-1:0] bin_count [4];
    logic [3:0]       refill_hit;
    logic [3:0]       dec;
    logic             handshake;
    logic             pick_found;
    coin_t            pick;
    coin_t            c;

    assign handshake  = coin_valid & coin_ready;
    assign refill_hit = refill_valid ? (4'b1 << refill_type) : 4'b0;
    assign dec        = handshake ? (4'b1 << coin_sel) : 4'b0;
    assign coin_type  = coin_sel;

    change_dispenser_coin_bin #(.INV_W(INV_W), .INIT(NICKEL_INIT)) u_nickel (
        .clk(clk), .reset(reset), .inc(refill_hit[0]), .inc_count(refill_count),
        .dec(dec[0]), .count(bin_count[0]), .empty(bin_empty[0])
    );

    change_dispenser_coin_bin #(.INV_W(INV_W), .INIT(DIME_INIT)) u_dime (
        .clk(clk), .reset(reset), .inc(refill_hit[1]), .inc_count(refill_count),
        .dec(dec[1]), .count(bin_count[1]), .empty(bin_empty[1])
    );

    change_dispenser_coin_bin #(.INV_W(INV_W), .INIT(QUARTER_INIT)) u_quarter (
        .clk(clk), .reset(reset), .inc(refill_hit[2]), .inc_count(refill_count),
        .dec(dec[2]), .count(bin_count[2]), .empty(bin_empty[2])
    );

    change_dispenser_coin_bin #(.INV_W(INV_W), .INIT(DOLLAR_INIT)) u_dollar (
        .clk(clk), .reset(reset), .inc(refill_hit[3]), .inc_count(refill_count),
        .dec(dec[3]), .count(bin_count[3]), .empty(bin_empty[3])
    );

    // Largest coin that fits in the remainder and has stock wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = CoinNickel;
        c          = CoinNickel;
        for (int unsigned k = 0; k < 4; k++) begin
            c = coin_t'(2'(3 - k));
            if (!pick_found && bin_count[c] != '0 &&
                AMOUNT_W'(coin_value(c)) <= remaining) begin
                pick_found = 1'b1;
                pick       = c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            remaining  <= '0;
            coin_sel   <= CoinNickel;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shortfall  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        remaining <= amount;
                        shortfall <= '0;
                        busy      <= 1'b1;
                        state     <= StSelect;
                    end
                end
                StSelect: begin
                    if (pick_found) begin
                        coin_sel   <= pick;
                        coin_valid <= 1'b1;
                        state      <= StIssue;
                    end else begin
                        shortfall <= remaining;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= StFinish;
                    end
                end
                StIssue: begin
                    if (coin_ready) begin
                        remaining  <= remaining - AMOUNT_W'(coin_value(coin_sel));
                        coin_valid <= 1'b0;
                        state      <= StSelect;
                    end
                end
                StFinish: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised and directed bench for change_dispenser against a behavioural greedy model.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] amount = '0;
    logic       coin_ready = 1'b0;
    logic       refill_valid = 1'b0;
    logic [1:0] refill_type = '0;
    logic [7:0] refill_count = '0;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       busy;
    logic       done;
    logic [8:0] shortfall;
    logic [3:0] bin_empty;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMOUNT_W(9), .INV_W(8), .NICKEL_INIT(40), .DIME_INIT(40),
        .QUARTER_INIT(40), .DOLLAR_INIT(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
        .refill_valid(refill_valid), .refill_type(refill_type),
        .refill_count(refill_count), .busy(busy), .done(done),
        .shortfall(shortfall), .bin_empty(bin_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t: bound expired", name, $time);
    endtask

    // Behavioural model: request phase, remainder, inventory, greedy choice.
    localparam int PH_IDLE = 0, PH_SEL = 1, PH_ISS = 2, PH_FIN = 3;
    int val [4]      = '{5, 10, 25, 100};
    int init_inv [4] = '{40, 40, 40, 20};
    int ph, m_rem, m_short, m_type, pick;
    int m_inv [4];
    int nxt [4];
    bit m_init = 1'b0;
    int coins [$];

    function automatic int greedy(input int rem);
        for (int d = 3; d >= 0; d--)
            if (m_inv[d] > 0 && val[d] <= rem) return d;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (m_init) begin
            check("coin_valid", coin_valid, ph == PH_ISS);
            if (ph == PH_ISS) check("coin_type", coin_type, m_type);
            check("busy", busy, ph == PH_SEL || ph == PH_ISS);
            check("done", done, ph == PH_FIN);
            check("shortfall", shortfall, m_short);
            for (int i = 0; i < 4; i++) begin
                check("bin_count", dut.bin_count[i], m_inv[i]);
                check("bin_empty", bin_empty[i], m_inv[i] == 0);
            end
            if (coin_valid && coin_ready) coins.push_back(int'(coin_type));
        end
        if (reset) begin
            ph = PH_IDLE; m_rem = 0; m_short = 0; m_type = 0;
            for (int i = 0; i < 4; i++) m_inv[i] = init_inv[i];
            m_init = 1'b1;
        end else if (m_init) begin
            pick = greedy(m_rem);
            for (int i = 0; i < 4; i++) begin
                nxt[i] = m_inv[i];
                if (refill_valid && refill_type == 2'(i)) begin
                    nxt[i] = nxt[i] + int'(refill_count);
                    if (nxt[i] > 255) nxt[i] = 255;
                end
                if (ph == PH_ISS && coin_ready && m_type == i) nxt[i] = nxt[i] - 1;
            end
            case (ph)
                PH_IDLE: if (start) begin m_rem = int'(amount); m_short = 0; ph = PH_SEL; end
                PH_SEL: begin
                    if (pick >= 0) begin m_type = pick; ph = PH_ISS; end
                    else begin m_short = m_rem; ph = PH_FIN; end
                end
                PH_ISS: if (coin_ready) begin m_rem = m_rem - val[m_type]; ph = PH_SEL; end
                default: ph = PH_IDLE;
            endcase
            for (int i = 0; i < 4; i++) m_inv[i] = nxt[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                return;
            end
        end
        fail("done_timeout");
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (coin_valid === 1'b1) return;
        end
        fail("coin_valid_timeout");
    endtask

    task automatic run_req(input int amt, output int cyc);
        coins.delete();
        start = 1'b1;
        amount = 9'(amt);
        tick();
        start = 1'b0;
        wait_done(cyc);
        tick();
    endtask

    task automatic check_coins(input string name, input int exp [$]);
        check({name, "_len"}, coins.size(), exp.size());
        for (int i = 0; i < exp.size() && i < coins.size(); i++)
            check(name, coins[i], exp[i]);
    endtask

    task automatic check_bins(input string name, input int n, input int d, input int q, input int o);
        check({name, "_nickel"}, dut.bin_count[0], n);
        check({name, "_dime"}, dut.bin_count[1], d);
        check({name, "_quarter"}, dut.bin_count[2], q);
        check({name, "_dollar"}, dut.bin_count[3], o);
    endtask

    initial begin
        int cyc;
        int hs;
        int guard;
        #1;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", coin_valid, 0);
        check("rst_empty", bin_empty, 0);
        check_bins("rst", 40, 40, 40, 20);
        tick();
        reset = 1'b0;
        coin_ready = 1'b1;
        tick();

        run_req(190, cyc);
        check_coins("t1_coins", '{3, 2, 2, 2, 1, 0});
        check("t1_short", shortfall, 0);
        check_bins("t1", 39, 39, 37, 19);

        run_req(37, cyc);
        check_coins("t2_coins", '{2, 1});
        check("t2_short", shortfall, 2);
        check("t2_nickel", dut.bin_count[0], 39);

        run_req(0, cyc);
        check("zero_latency", cyc, 1);
        check("zero_coins", coins.size(), 0);
        check("zero_short", shortfall, 0);

        // Stall the hopper for three cycles and pulse start mid-request.
        coins.delete();
        coin_ready = 1'b0;
        start = 1'b1;
        amount = 9'd15;
        tick();
        start = 1'b0;
        wait_valid();
        check("t4_valid1", coin_valid, 1);
        check("t4_type1", coin_type, 1);
        tick();
        start = 1'b1;
        amount = 9'd400;
        @(negedge clk);
        check("t4_valid2", coin_valid, 1);
        check("t4_type2", coin_type, 1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t4_valid3", coin_valid, 1);
        check("t4_type3", coin_type, 1);
        tick();
        coin_ready = 1'b1;
        wait_done(cyc);
        tick();
        check_coins("t4_coins", '{1, 0});
        check("t4_short", shortfall, 0);

        // Reset in the middle of a dispense.
        coins.delete();
        start = 1'b1;
        amount = 9'd190;
        tick();
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 50 && hs < 2; c++) begin
            @(negedge clk);
            if (coin_valid && coin_ready) hs++;
        end
        if (hs < 2) fail("t5_handshakes");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_valid", coin_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check_bins("t5", 40, 40, 40, 20);
        tick();
        run_req(5, cyc);
        check_coins("t5_after", '{0});
        check("t5_short", shortfall, 0);

        // Random requests, hopper stalls, refills and stray start pulses.
        for (int r = 0; r < 25; r++) begin
            coins.delete();
            start = 1'b1;
            amount = 9'($urandom_range(0, 511));
            tick();
            for (int c = 0; c < 500; c++) begin
                coin_ready = ($urandom_range(0, 3) != 0);
                refill_valid = ($urandom_range(0, 7) == 0);
                refill_type = 2'($urandom_range(0, 3));
                refill_count = 8'($urandom_range(0, 255));
                start = ($urandom_range(0, 9) == 0);
                amount = 9'($urandom_range(0, 511));
                @(negedge clk);
                if (done === 1'b1) break;
                if (c == 499) fail("rand_done_timeout");
                tick();
            end
            tick();
            start = 1'b0;
            refill_valid = 1'b0;
            coin_ready = 1'b1;
            tick();
        end

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        guard = 0;
        while (m_inv[2] > 0 && guard < 60) begin run_req(25, cyc); guard++; end
        run_req(50, cyc);
        check_coins("t3_coins", '{1, 1, 1, 1, 1});
        check("t3_short", shortfall, 0);
        check("t3_qempty", bin_empty[2], 1);

        guard = 0;
        while (m_inv[1] > 1 && guard < 60) begin run_req(10, cyc); guard++; end
        guard = 0;
        while (m_inv[0] > 0 && guard < 60) begin run_req(5, cyc); guard++; end
        check_bins("t6_pre", 0, 1, 0, 20);

        // Refill the dime bin in the same cycle as the first dime handshake.
        coins.delete();
        coin_ready = 1'b0;
        start = 1'b1;
        amount = 9'd20;
        tick();
        start = 1'b0;
        wait_valid();
        tick();
        coin_ready = 1'b1;
        refill_valid = 1'b1;
        refill_type = 2'd1;
        refill_count = 8'd5;
        tick();
        refill_valid = 1'b0;
        @(negedge clk);
        check("t6_dime_mid", dut.bin_count[1], 5);
        wait_done(cyc);
        tick();
        check_coins("t6_coins", '{1, 1});
        check("t6_short", shortfall, 0);
        check("t6_dime_end", dut.bin_count[1], 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
